channel_mixer: RTL and testbench

//  Sums the time-multiplexed OPL3 channel outputs of one sample period into stereo left/right samples.

---
 rtl/opl3_pkg.sv | 22 ++
 rtl/channel_mixer_sat_clamp.sv | 26 ++
 rtl/channel_mixer.sv | 135 +++++++++++++
 tb/tb_channel_mixer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 output mixer.
package opl3_pkg;

  localparam int NUM_CHANNELS     = 18;
  localparam int CH_WIDTH         = 16;
  localparam int DAC_OUTPUT_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT,
    OUT
  } mixer_state_t;

  // Observation bundle: FSM state plus the live clamp indications of both sums.
  typedef struct packed {
    mixer_state_t state;
    logic         sat_clip_l;
    logic         sat_clip_r;
  } mixer_dbg_t;

endpackage

// File: rtl/channel_mixer_sat_clamp.sv
// sat_clamp: combinational saturation of a signed IN_W-bit value into OUT_W bits,
// with a flag raised whenever the value had to be clamped.
module sat_clamp #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clipped
);
  import opl3_pkg::*;

  logic [IN_W-OUT_W:0] top_bits;

  // The value fits when every bit from the output sign bit upward equals the sign.
  assign top_bits = din[IN_W-1:OUT_W-1];
  assign clipped  = !((&top_bits) || !(|top_bits));

  always_comb begin
    dout = din[OUT_W-1:0];
    if (clipped) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/channel_mixer.sv
// channel_mixer: accumulates one sample period of OPL3 channel beats into saturated,
// left-justified stereo samples. Sticky clip flags exist only with OPL3_MIXER_CLIP_FLAG_EN.
module channel_mixer #(
  parameter int NUM_CHANNELS = opl3_pkg::NUM_CHANNELS,
  parameter int CH_WIDTH     = opl3_pkg::CH_WIDTH,
  parameter int OUT_WIDTH    = opl3_pkg::DAC_OUTPUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_clk_en,
  input  logic                        channel_valid,
  input  logic signed [CH_WIDTH-1:0]  channel_out,
  input  logic                        cha,
  input  logic                        chb,
  output logic signed [OUT_WIDTH-1:0] left_channel,
  output logic signed [OUT_WIDTH-1:0] right_channel,
  output logic                        sample_valid,
`ifdef OPL3_MIXER_CLIP_FLAG_EN
  output logic                        clip_l,
  output logic                        clip_r,
  input  logic                        clip_clear,
`endif
  output opl3_pkg::mixer_dbg_t        dbg
);
  import opl3_pkg::*;

  localparam int ACC_W = CH_WIDTH + $clog2(NUM_CHANNELS);
  localparam int CNT_W = $clog2(NUM_CHANNELS + 1);
  localparam int PAD_W = OUT_WIDTH - CH_WIDTH;

  mixer_state_t               state;
  logic signed [ACC_W-1:0]    acc_l, acc_r;
  logic signed [ACC_W-1:0]    ch_ext;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       start_pending;
  logic signed [CH_WIDTH-1:0] sat_l, sat_r, sat_l_q, sat_r_q;
  logic                       clip_now_l, clip_now_r;
  logic signed [OUT_WIDTH-1:0] left_ext, right_ext;

  // Beats are push-only: channel_valid qualifies channel_out/cha/chb for one cycle,
  // there is no back-pressure, and beats outside ACCUM are dropped.
  assign ch_ext    = ACC_W'(channel_out);
  assign left_ext  = OUT_WIDTH'(sat_l_q) <<< PAD_W;
  assign right_ext = OUT_WIDTH'(sat_r_q) <<< PAD_W;

  sat_clamp #(.IN_W(ACC_W), .OUT_W(CH_WIDTH)) u_sat_l (
    .din(acc_l), .dout(sat_l), .clipped(clip_now_l)
  );
  sat_clamp #(.IN_W(ACC_W), .OUT_W(CH_WIDTH)) u_sat_r (
    .din(acc_r), .dout(sat_r), .clipped(clip_now_r)
  );

  assign dbg = '{state: state, sat_clip_l: clip_now_l, sat_clip_r: clip_now_r};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      acc_l         <= '0;
      acc_r         <= '0;
      beat_cnt      <= '0;
      start_pending <= 1'b0;
      sat_l_q       <= '0;
      sat_r_q       <= '0;
      left_channel  <= '0;
      right_channel <= '0;
      sample_valid  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_clk_en) begin
            state    <= ACCUM;
            acc_l    <= '0;
            acc_r    <= '0;
            beat_cnt <= '0;
          end
        end
        ACCUM: begin
          // A strobe here means the period overran: restart without emitting.
          if (sample_clk_en) begin
            acc_l    <= '0;
            acc_r    <= '0;
            beat_cnt <= '0;
          end else if (channel_valid) begin
            if (cha) acc_l <= acc_l + ch_ext;
            if (chb) acc_r <= acc_r + ch_ext;
            if (beat_cnt == CNT_W'(NUM_CHANNELS - 1)) begin
              beat_cnt <= '0;
              state    <= SAT;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        SAT: begin
          sat_l_q       <= sat_l;
          sat_r_q       <= sat_r;
          start_pending <= sample_clk_en;
          state         <= OUT;
        end
        OUT: begin
          left_channel  <= left_ext;
          right_channel <= right_ext;
          sample_valid  <= 1'b1;
          start_pending <= 1'b0;
          if (start_pending || sample_clk_en) begin
            state    <= ACCUM;
            acc_l    <= '0;
            acc_r    <= '0;
            beat_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OPL3_MIXER_CLIP_FLAG_EN
  // A new clip in SAT takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_l <= 1'b0;
      clip_r <= 1'b0;
    end else begin
      if (state == SAT && clip_now_l) clip_l <= 1'b1;
      else if (clip_clear)            clip_l <= 1'b0;
      if (state == SAT && clip_now_r) clip_r <= 1'b1;
      else if (clip_clear)            clip_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_channel_mixer.sv
// Randomized bench for channel_mixer with a sum/clamp reference model and an expected-sample queue.
module tb_channel_mixer;
  import opl3_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_clk_en = 1'b0;
  logic        channel_valid = 1'b0;
  logic [15:0] channel_out = '0;
  logic        cha = 1'b0;
  logic        chb = 1'b0;
  logic [23:0] left_channel, right_channel;
  logic        sample_valid;
  mixer_dbg_t  dbg;
`ifdef OPL3_MIXER_CLIP_FLAG_EN
  logic        clip_l, clip_r;
  logic        clip_clear = 1'b0;
`endif

  channel_mixer dut (
    .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en),
    .channel_valid(channel_valid), .channel_out(channel_out), .cha(cha), .chb(chb),
    .left_channel(left_channel), .right_channel(right_channel), .sample_valid(sample_valid),
`ifdef OPL3_MIXER_CLIP_FLAG_EN
    .clip_l(clip_l), .clip_r(clip_r), .clip_clear(clip_clear),
`endif
    .dbg(dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // entry: {pulse cycle[31:0], clip_l, clip_r, left[23:0], right[23:0]}
  logic [81:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [23:0] last_l = '0, last_r = '0;
  bit          exp_clip_l = 1'b0, exp_clip_r = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clamp16(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic logic [23:0] to_dac(input int s);
    int t;
    t = clamp16(s) * 256;
    return t[23:0];
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [81:0] e;
    #1;
    cyc++;
    if (reset) begin
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_left", 32'(left_channel), 32'd0);
      check("rst_right", 32'(right_channel), 32'd0);
      check("rst_state", 32'(dbg.state), 32'(IDLE));
`ifdef OPL3_MIXER_CLIP_FLAG_EN
      check("rst_clip", {30'd0, clip_l, clip_r}, 32'd0);
`endif
      last_l = '0;
      last_r = '0;
    end else if (sample_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), e[81:50]);
        check("left", 32'(left_channel), 32'(e[47:24]));
        check("right", 32'(right_channel), 32'(e[23:0]));
`ifdef OPL3_MIXER_CLIP_FLAG_EN
        check("clip_l", 32'(clip_l), 32'(e[49]));
        check("clip_r", 32'(clip_r), 32'(e[48]));
`endif
        last_l = e[47:24];
        last_r = e[23:0];
      end
    end else begin
      check("hold_l", 32'(left_channel), 32'(last_l));
      check("hold_r", 32'(right_channel), 32'(last_r));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit en, input bit vld, input logic [15:0] d,
                       input bit a, input bit b, output int cap);
    @(negedge clk);
    sample_clk_en = en;
    channel_valid = vld;
    channel_out   = d;
    cha           = a;
    chb           = b;
    @(posedge clk);
    #2;
    cap           = cyc;
    sample_clk_en = 1'b0;
    channel_valid = 1'b0;
    channel_out   = '0;
    cha           = 1'b0;
    chb           = 1'b0;
  endtask

  task automatic idle_cycle(input bit junk);
    int cap;
    drive(1'b0, junk ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom_range(0, 65535)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cap);
  endtask

  task automatic strobe(input bit junk);
    int cap;
    drive(1'b1, junk, 16'($urandom_range(0, 65535)), 1'b1, 1'b1, cap);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #2;
    reset      = 1'b0;
    exp_clip_l = 1'b0;
    exp_clip_r = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // kind 0: fixed value/flags; kind 1: full-range random; kind 2: large same-sign values.
  task automatic run_period(input int kind, input int fval, input bit fa, input bit fb,
                            input int pre_idle, input int post_idle, input int abort_beats);
    int sl, sr, cap, sgn;
    logic signed [15:0] v;
    bit a, b;
    for (int i = 0; i < pre_idle; i++) idle_cycle(1'b1);
    if (abort_beats > 0) begin
      strobe(1'b0);
      for (int i = 0; i < abort_beats; i++)
        drive(1'b0, 1'b1, 16'($urandom_range(0, 65535)), 1'b1, 1'b1, cap);
      strobe(1'b0);
    end else begin
      strobe(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < post_idle; i++) idle_cycle(1'b0);
    sl  = 0;
    sr  = 0;
    sgn = $urandom_range(0, 1);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (kind == 0) begin
        v = 16'(fval);
        a = fa;
        b = fb;
      end else begin
        if ($urandom_range(0, 3) == 0) idle_cycle(1'b0);
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        if (kind == 1) v = 16'($urandom_range(0, 65535));
        else           v = 16'(sgn ? -$urandom_range(16000, 32768) : $urandom_range(16000, 32767));
      end
      drive(1'b0, 1'b1, v, a, b, cap);
      if (a) sl += int'(v);
      if (b) sr += int'(v);
    end
    exp_clip_l = exp_clip_l | (clamp16(sl) != sl);
    exp_clip_r = exp_clip_r | (clamp16(sr) != sr);
    exp_q.push_back({32'(cap + 2), exp_clip_l, exp_clip_r, to_dac(sl), to_dac(sr)});
  endtask

`ifdef OPL3_MIXER_CLIP_FLAG_EN
  task automatic clear_clips();
    wait_drain();
    @(negedge clk);
    clip_clear = 1'b1;
    @(posedge clk);
    #2;
    clip_clear = 1'b0;
    exp_clip_l = 1'b0;
    exp_clip_r = 1'b0;
    check("clip_clear", {30'd0, clip_l, clip_r}, 32'd0);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int cap;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    run_period(0, 1000, 1'b1, 1'b0, 2, 0, 0);
    run_period(0, 32767, 1'b1, 1'b1, 3, 0, 0);
    run_period(0, -32768, 1'b0, 1'b1, 3, 0, 0);
`ifdef OPL3_MIXER_CLIP_FLAG_EN
    clear_clips();
`endif
    run_period(0, 5, 1'b1, 1'b0, 3, 0, 10);

    // reset in mid-period: no pulse, outputs cleared, next period counts from zero
    wait_drain();
    strobe(1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 16'd777, 1'b1, 1'b1, cap);
    do_reset(2);
    run_period(0, -1234, 1'b1, 1'b1, 1, 0, 0);

    // strobe captured in OUT, then strobe captured in SAT
    run_period(0, 300, 1'b1, 1'b1, 1, 0, 0);
    run_period(0, -20, 1'b0, 1'b1, 0, 1, 0);
    run_period(1, 0, 1'b0, 1'b0, 2, 0, 0);

    for (int n = 0; n < 30; n++) begin
      int pre, post;
      pre  = $urandom_range(0, 4);
      post = (pre == 0) ? 1 : $urandom_range(0, 1);
      run_period($urandom_range(1, 2), 0, 1'b0, 1'b0, pre, post, 0);
`ifdef OPL3_MIXER_CLIP_FLAG_EN
      if (n % 6 == 5) clear_clips();
`endif
    end

    wait_drain();
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
